hkspi_slave_gen2: RTL and testbench
===================================

# hkspi_slave_gen2

Parametrised housekeeping SPI slave: the second-generation front end of the housekeeping register bank, reached through the management GPIO pins (SCK, CSB, SDI in; SDO out). It oversamples the SPI pins on the core `clock` and decodes read, write and read/write stream commands, plus n-byte commands. It drives a generic single-cycle register port, so one engine serves register banks of any depth. New over the previous generation: parametrised depth with address wrap, n-byte transfer termination, abort detection, and a reset-safe frame arm.

## Interface
- `ADDR_W`, 8: register address width; the address byte's low `ADDR_W` bits are used (≤ 8).
- `NUM_REGS`, 19: implemented registers. Addresses ≥ `NUM_REGS` read 0x00 and ignore writes.
- `WRAP`, 1: 1 = stream address wraps `NUM_REGS-1` → 0; 0 = wraps at `2**ADDR_W-1` → 0.
- `clock`  in  1  core clock; all logic on its rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `sck`, `csb`, `sdi`  in  1 each  raw SPI pins (asynchronous to `clock`).
- `sdo`  out  1  serial read data. Reset 0.
- `sdo_enb`  out  1  SDO pad enable, active-low. Reset 1.
- `reg_addr`  out  ADDR_W  register address. Reset 0.
- `reg_wdata`  out  8  write data. Reset 0x00.
- `reg_we`  out  1  one-cycle write strobe. Reset 0.
- `reg_re`  out  1  one-cycle read strobe. Reset 0.
- `reg_rdata`  in  8  read data; must be valid on the cycle after `reg_re`.
- `busy`  out  1  frame in progress. Reset 0.
- `abort`  out  1  one-cycle pulse when CSB rises with a partial byte. Reset 0.

## Operation
- Each pin passes through a 2-flop synchroniser and an edge detector. The bus is SPI mode 0: SDI is sampled on the detected SCK rise; SDO changes on the detected SCK fall. Data is MSB first.
- FSM states: `ARM`, `IDLE`, `CMD`, `ADDR`, `DATA`.
  - `ARM`: entered from reset. Moves to `IDLE` only after synchronised CSB is seen high, so a frame already in progress at reset release is ignored.
  - `IDLE`: moves to `CMD` on synchronised CSB fall.
  - `CMD`: after 8 bits, moves to `ADDR`.
  - `ADDR`: after 8 bits, loads `reg_addr` and moves to `DATA`.
  - Any state except `ARM` returns to `IDLE` on synchronised CSB high.
- Command byte:
  - Bits [7:6]: 00 = no-op (frame ignored to CSB high), 01 = read, 10 = write, 11 = read/write.
  - Bits [5:3] = n: 0 = stream until CSB high; 1–7 = n data bytes, after which SDI is ignored and `sdo_enb` is 1 until CSB high.
  - Bits [2:0] are ignored.
- Read (01 or 11):
  - `reg_re` pulses on the cycle the address byte completes, and again on each data-byte completion that is not the last of an n-byte transfer.
  - `reg_rdata` is latched into the shift register the following cycle.
  - Bit 7 is presented on the next SCK fall; `sdo_enb` is 0 from that fall until CSB high.
- Write (10 or 11): on each completed data byte, `reg_wdata` is set to the byte and `reg_we` pulses for one cycle, with `reg_addr` still at the current address.
- Read/write: the `reg_re` for address a+1 follows the `reg_we` to address a by exactly one cycle.
- Address increments by 1 after each data byte, with wrap per `WRAP`/`NUM_REGS`.
- Out-of-range addresses: `reg_we` is suppressed; SDO shifts 0x00.
- Abort: CSB high with bit count ≠ 0 in `CMD`, `ADDR` or `DATA` pulses `abort`. The partial byte is discarded and no `reg_we` is issued.

## Timing
- SCK high and low phases must each be ≥ 4 `clock` periods; CSB setup to first SCK rise must be ≥ 4 periods.
- Pin-to-action latency is 3 cycles (2 sync + 1 edge detect).
- `reg_we`/`reg_re` assert 1 cycle after the detected edge of the byte's 8th bit.
- SDO is valid ≤ 4 cycles after the SCK fall pin edge.
- `busy` rises 3 cycles after the CSB fall and clears 3 cycles after the CSB rise.
- An SCK edge and a CSB rise detected in the same cycle: CSB wins and the edge is ignored.
- Asserting `resetb` clears all outputs to their reset values immediately; no strobe is issued.

## Structure
- Package `hkspi_pkg`: command opcode constants (`CMD_NOP`, `CMD_RD`, `CMD_WR`, `CMD_RW`), FSM state enum, n-field position constants.
- Sub-module `hkspi_pin_sync`: 2-flop synchroniser with rise/fall pulse outputs, instantiated for `sck`, `csb` and `sdi` (`sdi` uses level only).

## Test plan
- Preload reg 3 = 0x11; send 0x40, 0x03, then read 1 byte → SDO byte 0x11, exactly one `reg_re` with `reg_addr` = 3, then `sdo_enb` returns to 1 after CSB high.
- Send 0x80, 0x0b, 0x01 → exactly one `reg_we` with `reg_addr` = 0x0b and `reg_wdata` = 0x01. Repeat with data 0x00 → register returns to 0x00.
- `NUM_REGS` = 19, `WRAP` = 1; stream-read (0x40) from 0x00 for 20 bytes → regs 0..18 in order, then reg 0 again (expected 0x00, 0x04, 0x56, 0x11, …, 0x04, 0x00).
- n-byte mode: send 0x50 (read, n = 2), address 0x01, clock 3 bytes → 2 `reg_re` pulses (addresses 1, 2); third byte SDO = 0 with `sdo_enb` = 1.
- Abort: send 0x80, 0x05, then 5 data bits and raise CSB → one `abort` pulse, no `reg_we`, `busy` low 3 cycles later.
- Deassert `resetb` while CSB is low mid-frame, clock 16 bits → no strobes. Raise CSB, then issue a normal read of reg 3 → 0x11.

Source files
------------

// File: rtl/hkspi_pkg.sv
// Shared definitions for the second-generation housekeeping SPI slave:
// command opcodes, command-byte field positions and the frame FSM states.
package hkspi_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RW  = 2'b11;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int N_MSB  = 5;
  localparam int N_LSB  = 3;

  typedef enum logic [2:0] {
    ARM  = 3'd0,
    IDLE = 3'd1,
    CMD  = 3'd2,
    ADDR = 3'd3,
    DATA = 3'd4
  } state_t;

endpackage

// File: rtl/hkspi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with registered history
// so single-cycle rise/fall pulses can be derived from the synchronised level.
module hkspi_pin_sync (
  input  logic clock,
  input  logic resetb,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic last;

  // Resetting to 0 makes an idle-high pin show a rise after reset, which arms the slave.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      meta <= 1'b0;
      sync <= 1'b0;
      last <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      last <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~last;
  assign fall  = ~sync & last;

endmodule

// File: rtl/hkspi_slave_gen2.sv
// Housekeeping SPI slave (mode 0, MSB first) driving a generic single-cycle
// register port; supports stream and n-byte read, write and read/write frames.
module hkspi_slave_gen2
  import hkspi_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 19,
  parameter int WRAP     = 1
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_enb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              abort
);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    in_range = (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (WRAP != 0 && int'(a) >= NUM_REGS - 1) next_addr = '0;
    else next_addr = a + ADDR_W'(1);
  endfunction

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic csb_lvl, csb_rise_unused, csb_fall;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  hkspi_pin_sync u_sck (.clock(clock), .resetb(resetb), .pin(sck),
                        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  hkspi_pin_sync u_csb (.clock(clock), .resetb(resetb), .pin(csb),
                        .level(csb_lvl), .rise(csb_rise_unused), .fall(csb_fall));
  hkspi_pin_sync u_sdi (.clock(clock), .resetb(resetb), .pin(sdi),
                        .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic [1:0]  op;
  logic [2:0]  n_left;
  logic        n_mode;
  logic        halt;
  logic        advance;
  logic        rd_wait;

  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {shift_in, sdi_lvl};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);

  // Frame FSM: bit/byte framing, register strobes, read-data pipeline and SDO shifter.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= ARM;
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'h00;
      op        <= CMD_NOP;
      n_left    <= 3'd0;
      n_mode    <= 1'b0;
      halt      <= 1'b0;
      advance   <= 1'b0;
      rd_wait   <= 1'b0;
      sdo       <= 1'b0;
      sdo_enb   <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      abort   <= 1'b0;
      rd_wait <= reg_re;
      if (rd_wait) shift_out <= in_range(reg_addr) ? reg_rdata : 8'h00;
      // Address moves one cycle after the byte so reg_we still sees the old address.
      if (advance) begin
        advance  <= 1'b0;
        reg_addr <= next_addr(reg_addr);
        reg_re   <= op[0] & ~halt;
      end

      if (state == ARM) begin
        if (csb_lvl) state <= IDLE;
        else state <= ARM;
      end else if (csb_lvl) begin
        // CSB high outranks any SCK edge seen in the same cycle.
        state   <= IDLE;
        abort   <= (bit_cnt != 3'd0);
        bit_cnt <= 3'd0;
        busy    <= 1'b0;
        sdo     <= 1'b0;
        sdo_enb <= 1'b1;
        advance <= 1'b0;
        reg_re  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csb_fall) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= 3'd0;
              halt    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          CMD: begin
            if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= rx_byte[6:0];
            end
            if (byte_done) begin
              op     <= rx_byte[OP_MSB:OP_LSB];
              n_left <= rx_byte[N_MSB:N_LSB];
              n_mode <= (rx_byte[N_MSB:N_LSB] != 3'd0);
              if (rx_byte[OP_MSB:OP_LSB] == CMD_NOP) begin
                state <= DATA;
                halt  <= 1'b1;
              end else begin
                state <= ADDR;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= rx_byte[6:0];
            end
            if (byte_done) begin
              reg_addr <= rx_byte[ADDR_W-1:0];
              reg_re   <= op[0];
              state    <= DATA;
            end
          end
          DATA: begin
            if (halt) begin
              state <= DATA;
            end else if (sck_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                if (op[1]) begin
                  reg_wdata <= rx_byte;
                  reg_we    <= in_range(reg_addr);
                end
                advance <= 1'b1;
                if (n_mode) begin
                  n_left <= n_left - 3'd1;
                  if (n_left == 3'd1) begin
                    halt    <= 1'b1;
                    sdo     <= 1'b0;
                    sdo_enb <= 1'b1;
                  end
                end
              end
            end else if (sck_fall && op[0]) begin
              sdo       <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
              sdo_enb   <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hkspi_slave_gen2.sv
// Directed/randomised bench for hkspi_slave_gen2 with a behavioural register-bank model.
module tb_hkspi_slave_gen2;

  localparam int HALF  = 6;
  localparam int NREGS = 19;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       sck = 1'b0;
  logic       csb = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       sdo_enb;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       abort;

  hkspi_slave_gen2 #(.ADDR_W(8), .NUM_REGS(NREGS), .WRAP(1)) dut (
    .clock(clock), .resetb(resetb), .sck(sck), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_enb(sdo_enb), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .abort(abort)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0] model  [0:255];
  logic [7:0] bank   [0:255];
  logic [7:0] re_log [0:255];
  logic [7:0] tx_buf [0:31];
  logic [7:0] rx_buf [0:31];
  logic       pre_en = 1'b0;
  logic [7:0] pre_a = 8'h00;
  logic [7:0] pre_d = 8'h00;
  int re_cnt = 0, we_cnt = 0, abort_cnt = 0;
  logic [7:0] last_we_addr = 8'h00, last_we_data = 8'h00;

  // Register bank the DUT drives; out-of-range entries hold garbage on purpose.
  always @(posedge clock) begin
    if (pre_en) bank[pre_a] <= pre_d;
    else if (reg_we) bank[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bank[reg_addr];
  end

  // Strobe monitors.
  always @(posedge clock) begin
    if (reg_re) begin
      re_log[re_cnt % 256] <= reg_addr;
      re_cnt <= re_cnt + 1;
    end
    if (reg_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= reg_addr;
      last_we_data <= reg_wdata;
    end
    if (abort) abort_cnt <= abort_cnt + 1;
  end

  function automatic logic [7:0] exp_rd(input int a);
    exp_rd = (a < NREGS) ? model[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], sdo};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input int nbytes);
    logic [7:0] rxb;
    csb = 1'b0;
    wait_clk(HALF);
    spi_bits(cmd, 8, rxb);
    spi_bits(addr, 8, rxb);
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(tx_buf[i], 8, rxb);
      rx_buf[i] = rxb;
    end
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    csb = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    int re0, we0, ab0, hits, a;
    logic [7:0] rxb, d0, d1;

    model[0] = 8'h00; model[1] = 8'h04; model[2] = 8'h56; model[3] = 8'h11;
    for (int i = 4; i < NREGS; i++) model[i] = 8'($urandom_range(255));
    for (int i = NREGS; i < 32; i++) model[i] = 8'hE0 | 8'($urandom_range(31));
    wait_clk(1);
    for (int i = 0; i < 32; i++) begin
      pre_en = 1'b1; pre_a = 8'(i); pre_d = model[i];
      wait_clk(1);
    end
    pre_en = 1'b0;

    check("rst_sdo", sdo, 0);
    check("rst_sdo_enb", sdo_enb, 1);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_strobes", {reg_we, reg_re, busy, abort}, 0);
    resetb = 1'b1;
    wait_clk(10);

    // Single read of reg 3 in stream mode.
    re0 = re_cnt;
    xfer(8'h40, 8'h03, 1);
    check("rd3_data", rx_buf[0], 8'h11);
    check("rd3_busy", busy, 1);
    check("rd3_sdo_enb_active", sdo_enb, 0);
    end_frame();
    hits = 0;
    for (int i = re0; i < re_cnt; i++) if (re_log[i % 256] == 8'h03) hits++;
    check("rd3_re_at_3", hits, 1);
    check("rd3_sdo_enb_idle", sdo_enb, 1);
    check("rd3_busy_idle", busy, 0);

    // Write 0x01 then 0x00 to reg 0x0b, reading each back with n=1.
    for (int k = 0; k < 2; k++) begin
      we0 = we_cnt;
      tx_buf[0] = (k == 0) ? 8'h01 : 8'h00;
      xfer(8'h80, 8'h0b, 1);
      end_frame();
      model[11] = tx_buf[0];
      check("wr_we_count", we_cnt - we0, 1);
      check("wr_we_addr", last_we_addr, 8'h0b);
      check("wr_we_data", last_we_data, tx_buf[0]);
      re0 = re_cnt;
      xfer(8'h48, 8'h0b, 1);
      end_frame();
      check("wr_readback", rx_buf[0], model[11]);
      check("n1_re_count", re_cnt - re0, 1);
    end

    // Stream read of 20 bytes from 0 wraps back to reg 0.
    re0 = re_cnt;
    xfer(8'h40, 8'h00, 20);
    end_frame();
    for (int i = 0; i < 20; i++) check($sformatf("stream_b%0d", i), rx_buf[i], exp_rd(i % NREGS));
    check("stream_re_count", re_cnt - re0, 21);
    check("stream_re_last", re_log[(re0 + 18) % 256], 8'd18);
    check("stream_re_wrap", re_log[(re0 + 19) % 256], 8'd0);

    // n-byte read (n=2) clocked for 3 bytes.
    re0 = re_cnt;
    xfer(8'h50, 8'h01, 3);
    check("nb_sdo_enb_after", sdo_enb, 1);
    end_frame();
    check("nb_re_count", re_cnt - re0, 2);
    check("nb_re_addr0", re_log[re0 % 256], 8'd1);
    check("nb_re_addr1", re_log[(re0 + 1) % 256], 8'd2);
    check("nb_byte0", rx_buf[0], model[1]);
    check("nb_byte1", rx_buf[1], model[2]);
    check("nb_byte2", rx_buf[2], 8'h00);

    // Random single writes (in and out of range) with readback.
    for (int k = 0; k < 5; k++) begin
      a = (k == 4) ? NREGS + $urandom_range(5) : 4 + $urandom_range(NREGS - 5);
      tx_buf[0] = 8'($urandom_range(255));
      we0 = we_cnt;
      xfer(8'h88, 8'(a), 1);
      end_frame();
      check("rw_we_count", we_cnt - we0, (a < NREGS) ? 1 : 0);
      if (a < NREGS) model[a] = tx_buf[0];
      xfer(8'h48, 8'(a), 1);
      end_frame();
      check("rnd_readback", rx_buf[0], exp_rd(a));
    end

    // Read/write n=2: returns old contents, writes new ones.
    a = 4 + $urandom_range(NREGS - 6);
    d0 = 8'($urandom_range(255));
    d1 = 8'($urandom_range(255));
    tx_buf[0] = d0; tx_buf[1] = d1;
    re0 = re_cnt; we0 = we_cnt;
    xfer(8'hD0, 8'(a), 2);
    end_frame();
    check("rwx_old0", rx_buf[0], model[a]);
    check("rwx_old1", rx_buf[1], model[a+1]);
    check("rwx_we_count", we_cnt - we0, 2);
    check("rwx_re_count", re_cnt - re0, 2);
    model[a] = d0; model[a+1] = d1;
    xfer(8'h50, 8'(a), 2);
    end_frame();
    check("rwx_new0", rx_buf[0], d0);
    check("rwx_new1", rx_buf[1], d1);

    // Abort: partial data byte then CSB high.
    we0 = we_cnt; ab0 = abort_cnt;
    xfer(8'h80, 8'h05, 0);
    spi_bits(8'hA5, 5, rxb);
    wait_clk(HALF);
    csb = 1'b1;
    wait_clk(1);
    check("abort_busy_hold", busy, 1);
    wait_clk(3);
    check("abort_busy_low", busy, 0);
    wait_clk(4);
    check("abort_count", abort_cnt - ab0, 1);
    check("abort_no_we", we_cnt - we0, 0);
    xfer(8'h48, 8'h05, 1);
    end_frame();
    check("abort_reg_kept", rx_buf[0], model[5]);

    // Reset mid-frame: frame in progress at release must be ignored.
    csb = 1'b0;
    wait_clk(HALF);
    resetb = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sdo_enb", sdo_enb, 1);
    wait_clk(3);
    resetb = 1'b1;
    re0 = re_cnt; we0 = we_cnt;
    spi_bits(8'h80, 8, rxb);
    spi_bits(8'($urandom_range(255)), 8, rxb);
    check("midrst_no_strobes", (re_cnt - re0) + (we_cnt - we0), 0);
    check("midrst_busy_frame", busy, 0);
    end_frame();
    xfer(8'h40, 8'h03, 1);
    end_frame();
    check("midrst_read3", rx_buf[0], 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
